mainfsm_fpu: RTL and testbench

//  Multicycle main control FSM of the ARM-subset core, extended with an FPU

---
 rtl/mainfsm_fpu_pkg.sv | 84 ++++++++
 rtl/fpu_wait_ctr.sv | 39 +++
 rtl/mainfsm_fpu.sv | 119 +++++++++++
 tb/tb_mainfsm_fpu.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mainfsm_fpu_pkg.sv
// Shared definitions for the multicycle main FSM: state encoding, Op codes and
// the per-state Moore control words.
package mainfsm_fpu_pkg;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StFpuStart = 4'd10,
      StFpuWait  = 4'd11,
      StFpuWb    = 4'd12
   } state_e;

   localparam logic [1:0] OpDp  = 2'b00;
   localparam logic [1:0] OpMem = 2'b01;
   localparam logic [1:0] OpBr  = 2'b10;
   localparam logic [1:0] OpFpu = 2'b11;

   typedef struct packed {
      logic       adr_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic       alu_op;
      logic       ir_write;
      logic       next_pc;
      logic       branch;
      logic       reg_w;
      logic       mem_w;
      logic       fpu_w;
      logic       fpu_start;
      logic       busy_fpu;
   } ctrl_t;

   localparam ctrl_t CtrlNone = '0;

   // ir_write/next_pc/mem_w are qualified by MemReady in the top.
   localparam ctrl_t CtrlFetch = '{alu_src_a: 2'b01, alu_src_b: 2'b10, result_src: 2'b10,
                                   ir_write: 1'b1, next_pc: 1'b1, default: '0};
   localparam ctrl_t CtrlDecode = '{alu_src_a: 2'b01, alu_src_b: 2'b10, result_src: 2'b10,
                                    default: '0};
   localparam ctrl_t CtrlMemAdr = '{alu_src_a: 2'b00, alu_src_b: 2'b01, default: '0};
   localparam ctrl_t CtrlMemRd = '{adr_src: 1'b1, result_src: 2'b00, default: '0};
   localparam ctrl_t CtrlMemWb = '{result_src: 2'b01, reg_w: 1'b1, default: '0};
   localparam ctrl_t CtrlMemWr = '{adr_src: 1'b1, result_src: 2'b00, mem_w: 1'b1, default: '0};
   localparam ctrl_t CtrlExecR = '{alu_src_a: 2'b00, alu_src_b: 2'b00, alu_op: 1'b1,
                                   default: '0};
   localparam ctrl_t CtrlExecI = '{alu_src_a: 2'b00, alu_src_b: 2'b01, alu_op: 1'b1,
                                   default: '0};
   localparam ctrl_t CtrlAluWb = '{result_src: 2'b00, reg_w: 1'b1, default: '0};
   localparam ctrl_t CtrlBranch = '{alu_src_a: 2'b10, alu_src_b: 2'b01, result_src: 2'b10,
                                    branch: 1'b1, default: '0};
   localparam ctrl_t CtrlFpuStart = '{fpu_start: 1'b1, busy_fpu: 1'b1, default: '0};
   localparam ctrl_t CtrlFpuWait = '{busy_fpu: 1'b1, default: '0};
   localparam ctrl_t CtrlFpuWb = '{result_src: 2'b11, fpu_w: 1'b1, busy_fpu: 1'b1,
                                   default: '0};

   function automatic ctrl_t ctrl_word(input state_e st);
      case (st)
         StFetch:    ctrl_word = CtrlFetch;
         StDecode:   ctrl_word = CtrlDecode;
         StMemAdr:   ctrl_word = CtrlMemAdr;
         StMemRd:    ctrl_word = CtrlMemRd;
         StMemWb:    ctrl_word = CtrlMemWb;
         StMemWr:    ctrl_word = CtrlMemWr;
         StExecR:    ctrl_word = CtrlExecR;
         StExecI:    ctrl_word = CtrlExecI;
         StAluWb:    ctrl_word = CtrlAluWb;
         StBranch:   ctrl_word = CtrlBranch;
         StFpuStart: ctrl_word = CtrlFpuStart;
         StFpuWait:  ctrl_word = CtrlFpuWait;
         StFpuWb:    ctrl_word = CtrlFpuWb;
         default:    ctrl_word = CtrlNone;
      endcase
   endfunction

endpackage

// File: rtl/fpu_wait_ctr.sv
// FPU wait counter: synchronous clear, count enable, saturates at all-ones and
// flags the terminal count.
module fpu_wait_ctr #(
   parameter int unsigned TW       = 6,
   parameter int unsigned Terminal = 31
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [TW-1:0] count_o,
   output logic          term_o
);

   localparam logic [TW-1:0] TermVal = TW'(Terminal);

   logic [TW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != '1)) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign term_o  = (count_q == TermVal);

endmodule

// File: rtl/mainfsm_fpu.sv
// Multicycle main control FSM with an FPU issue/wait/writeback path. Outputs are
// decoded from state and forced low while reset is asserted.
module mainfsm_fpu
   import mainfsm_fpu_pkg::*;
#(
   parameter int unsigned FPU_TIMEOUT = 32,
   parameter int unsigned TW          = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   input  logic       fpu_done,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       ALUOp,
   output logic       NextPC,
   output logic       Branch,
   output logic       RegW,
   output logic       MemW,
   output logic       FPUW,
   output logic       fpu_start,
   output logic       fpu_timeout,
   output logic       busy_fpu
);

   state_e        state_q, state_d;
   logic [TW-1:0] wait_cnt;
   logic          wait_term;
   ctrl_t         ctrl;
   logic          timeout;
   logic          unused_sig;

   fpu_wait_ctr #(
      .TW       (TW),
      .Terminal (FPU_TIMEOUT - 1)
   ) u_wait_ctr (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clr_i   (state_q == StFpuStart),
      .en_i    (state_q == StFpuWait),
      .count_o (wait_cnt),
      .term_o  (wait_term)
   );

   assign unused_sig = ^{Funct[4:1], wait_cnt};

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = MemReady ? StDecode : StFetch;
         StDecode: begin
            case (Op)
               OpMem:   state_d = StMemAdr;
               OpDp:    state_d = Funct[5] ? StExecI : StExecR;
               OpBr:    state_d = StBranch;
               default: state_d = StFpuStart;
            endcase
         end
         StMemAdr:   state_d = Funct[0] ? StMemRd : StMemWr;
         StMemRd:    state_d = MemReady ? StMemWb : StMemRd;
         StMemWr:    state_d = MemReady ? StFetch : StMemWr;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StFpuStart: state_d = StFpuWait;
         // A result arriving on the terminal cycle still wins over the abort.
         StFpuWait: begin
            if (fpu_done) begin
               state_d = StFpuWb;
            end else if (wait_term) begin
               state_d = StFetch;
            end else begin
               state_d = StFpuWait;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctrl          = ctrl_word(state_q);
      ctrl.ir_write = ctrl.ir_write & MemReady;
      ctrl.next_pc  = ctrl.next_pc & MemReady;
      ctrl.mem_w    = ctrl.mem_w & MemReady;
      timeout       = (state_q == StFpuWait) & wait_term & ~fpu_done;
      if (!reset) begin
         ctrl    = CtrlNone;
         timeout = 1'b0;
      end
   end

   assign IRWrite     = ctrl.ir_write;
   assign AdrSrc      = ctrl.adr_src;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ResultSrc   = ctrl.result_src;
   assign ALUOp       = ctrl.alu_op;
   assign NextPC      = ctrl.next_pc;
   assign Branch      = ctrl.branch;
   assign RegW        = ctrl.reg_w;
   assign MemW        = ctrl.mem_w;
   assign FPUW        = ctrl.fpu_w;
   assign fpu_start   = ctrl.fpu_start;
   assign fpu_timeout = timeout;
   assign busy_fpu    = ctrl.busy_fpu;

endmodule

// File: tb/tb_mainfsm_fpu.sv
// Bench for mainfsm_fpu: per-instruction cycle templates built from the
// instruction-level behaviour, with random wait lengths and input noise.
module tb_mainfsm_fpu;

   localparam int TO = 32;

   localparam logic [8:0] S_IR    = 9'h100;
   localparam logic [8:0] S_NPC   = 9'h080;
   localparam logic [8:0] S_REGW  = 9'h040;
   localparam logic [8:0] S_MEMW  = 9'h020;
   localparam logic [8:0] S_FPUW  = 9'h010;
   localparam logic [8:0] S_BR    = 9'h008;
   localparam logic [8:0] S_START = 9'h004;
   localparam logic [8:0] S_TMO   = 9'h002;
   localparam logic [8:0] S_BUSY  = 9'h001;

   // sel = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
   localparam logic [6:0] FETCH_M = 7'h7F;
   localparam logic [6:0] FETCH_V = 7'b0_01_10_10;
   localparam logic [6:0] ADR_M   = 7'b1_00_00_00;

   typedef struct packed {
      logic       mr;
      logic       fd;
      logic [8:0] strb;
      logic [6:0] sel_m;
      logic [6:0] sel;
      logic       alu;
   } cyc_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic       MemReady, fpu_done;
   logic       IRWrite, AdrSrc, ALUOp, NextPC, Branch, RegW, MemW, FPUW;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic       fpu_start, fpu_timeout, busy_fpu;

   logic [8:0]  strb;
   logic [6:0]  sel;
   logic [16:0] allout;
   int          checks = 0;
   int          errors = 0;
   cyc_t        exp_q[$];

   always #5 clk = ~clk;

   mainfsm_fpu dut (
      .clk         (clk),
      .reset       (reset),
      .Op          (Op),
      .Funct       (Funct),
      .MemReady    (MemReady),
      .fpu_done    (fpu_done),
      .IRWrite     (IRWrite),
      .AdrSrc      (AdrSrc),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ResultSrc   (ResultSrc),
      .ALUOp       (ALUOp),
      .NextPC      (NextPC),
      .Branch      (Branch),
      .RegW        (RegW),
      .MemW        (MemW),
      .FPUW        (FPUW),
      .fpu_start   (fpu_start),
      .fpu_timeout (fpu_timeout),
      .busy_fpu    (busy_fpu)
   );

   assign strb   = {IRWrite, NextPC, RegW, MemW, FPUW, Branch, fpu_start, fpu_timeout, busy_fpu};
   assign sel    = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
   assign allout = {strb, sel, ALUOp};

   function automatic logic rb();
      return 1'($urandom_range(1, 0));
   endfunction

   task automatic push(input logic mr, input logic fd, input logic [8:0] s,
                       input logic [6:0] m, input logic [6:0] v, input logic alu);
      cyc_t c;
      c.mr = mr; c.fd = fd; c.strb = s; c.sel_m = m; c.sel = v; c.alu = alu;
      exp_q.push_back(c);
   endtask

   // Expected cycles of one instruction. Op/Funct are held for its whole life.
   // done_at: FPUWAIT cycle index carrying fpu_done; <0 or >=TO means never.
   task automatic model_instr(input logic [1:0] op, input logic [5:0] funct, input int fwait,
                              input int mwait, input int done_at);
      for (int i = 0; i < fwait; i++) push(1'b0, rb(), 9'h0, FETCH_M, FETCH_V, 1'b0);
      push(1'b1, rb(), S_IR | S_NPC, FETCH_M, FETCH_V, 1'b0);
      push(rb(), rb(), 9'h0, 7'h0, 7'h0, 1'b0);
      case (op)
         2'b00: begin
            push(rb(), rb(), 9'h0, 7'h0, 7'h0, 1'b1);
            push(rb(), rb(), S_REGW, 7'h0, 7'h0, 1'b0);
         end
         2'b01: begin
            push(rb(), rb(), 9'h0, 7'h0, 7'h0, 1'b0);
            for (int i = 0; i < mwait; i++) push(1'b0, rb(), 9'h0, ADR_M, ADR_M, 1'b0);
            if (funct[0]) begin
               push(1'b1, rb(), 9'h0, ADR_M, ADR_M, 1'b0);
               push(rb(), rb(), S_REGW, 7'h03, 7'h01, 1'b0);
            end else begin
               push(1'b1, rb(), S_MEMW, ADR_M, ADR_M, 1'b0);
            end
         end
         2'b10: push(rb(), rb(), S_BR, 7'h0F, 7'b0000110, 1'b0);
         default: begin
            push(rb(), rb(), S_START | S_BUSY, 7'h0, 7'h0, 1'b0);
            if (done_at >= 0 && done_at < TO) begin
               for (int i = 0; i < done_at; i++) push(rb(), 1'b0, S_BUSY, 7'h0, 7'h0, 1'b0);
               push(rb(), 1'b1, S_BUSY, 7'h0, 7'h0, 1'b0);
               push(rb(), rb(), S_FPUW | S_BUSY, 7'h03, 7'h03, 1'b0);
            end else begin
               for (int i = 0; i < TO - 1; i++) push(rb(), 1'b0, S_BUSY, 7'h0, 7'h0, 1'b0);
               push(rb(), 1'b0, S_TMO | S_BUSY, 7'h0, 7'h0, 1'b0);
            end
         end
      endcase
   endtask

   task automatic test_reset();
      reset = 1'b0; MemReady = 1'b1; fpu_done = 1'b1; Op = 2'b11; Funct = 6'h3F;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (allout !== 17'h0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: got %b, expected all zero", i, allout);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1; fpu_done = 1'b0;
      @(negedge clk);
      checks++;
      if ({IRWrite, NextPC} !== 2'b11 || strb[6:0] !== 7'h0) begin
         errors++;
         $display("FAIL reset_release: got strb=%b, expected %b", strb, S_IR | S_NPC);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if (allout !== 17'h0) begin
         errors++;
         $display("FAIL reset_async: got %b, expected all zero", allout);
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_ldr();
      int n = 0;
      Op = 2'b01; Funct = 6'b000001;
      model_instr(2'b01, 6'b000001, 0, 2, -1);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel || (it.alu && ALUOp !== 1'b1)) begin
            errors++;
            $display("FAIL ldr cyc %0d: got strb=%b sel=%b aluop=%b, expected strb=%b sel=%b",
                     n, strb, sel & it.sel_m, ALUOp, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_addi();
      int n = 0;
      Op = 2'b00; Funct = 6'b100000;
      model_instr(2'b00, 6'b100000, 0, 0, -1);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel || (it.alu && ALUOp !== 1'b1)) begin
            errors++;
            $display("FAIL addi cyc %0d: got strb=%b sel=%b aluop=%b, expected strb=%b sel=%b",
                     n, strb, sel & it.sel_m, ALUOp, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch_store();
      int n = 0;
      Op = 2'b10; Funct = 6'h00;
      model_instr(2'b10, 6'h00, 1, 0, -1);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel || (it.alu && ALUOp !== 1'b1)) begin
            errors++;
            $display("FAIL branch cyc %0d: got strb=%b sel=%b, expected strb=%b sel=%b",
                     n, strb, sel & it.sel_m, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
      Op = 2'b01; Funct = 6'b000000;
      model_instr(2'b01, 6'b000000, 0, 3, -1);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel || (it.alu && ALUOp !== 1'b1)) begin
            errors++;
            $display("FAIL store cyc %0d: got strb=%b sel=%b, expected strb=%b sel=%b",
                     n, strb, sel & it.sel_m, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   // Covers done after 5 cycles, never done, and done on the terminal cycle.
   task automatic test_fpu(input string nm, input int done_at);
      int n = 0;
      Op = 2'b11; Funct = 6'($urandom);
      model_instr(2'b11, Funct, 0, 0, done_at);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel) begin
            errors++;
            $display("FAIL %s cyc %0d: got strb=%b sel=%b, expected strb=%b sel=%b",
                     nm, n, strb, sel & it.sel_m, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_fpu();
      int n = 0;
      Op = 2'b11; Funct = 6'h00;
      push(1'b1, 1'b0, S_IR | S_NPC, FETCH_M, FETCH_V, 1'b0);
      push(1'b0, 1'b0, 9'h0, 7'h0, 7'h0, 1'b0);
      push(1'b0, 1'b1, S_START | S_BUSY, 7'h0, 7'h0, 1'b0);
      for (int i = 0; i < 5; i++) push(1'b0, 1'b0, S_BUSY, 7'h0, 7'h0, 1'b0);
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb) begin
            errors++;
            $display("FAIL midrst_pre cyc %0d: got strb=%b, expected %b", n, strb, it.strb);
         end
         n++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
      #1;
      checks++;
      if (allout !== 17'h0) begin
         errors++;
         $display("FAIL midrst_async: got %b, expected all zero", allout);
      end
      fpu_done = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      fpu_done = 1'b0; reset = 1'b1;
      Op = 2'b10;
      model_instr(2'b10, 6'h00, 0, 0, -1);
      n = 0;
      while (exp_q.size() > 0) begin
         cyc_t it = exp_q.pop_front();
         MemReady = it.mr; fpu_done = it.fd;
         @(negedge clk);
         checks++;
         if (strb !== it.strb || (sel & it.sel_m) !== it.sel) begin
            errors++;
            $display("FAIL midrst_post cyc %0d: got strb=%b sel=%b, expected strb=%b sel=%b",
                     n, strb, sel & it.sel_m, it.strb, it.sel);
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 30; k++) begin
         int n = 0;
         int d = $urandom_range(40, 0);
         Op    = 2'($urandom);
         Funct = 6'($urandom);
         model_instr(Op, Funct, $urandom_range(3, 0), $urandom_range(3, 0), (d >= TO) ? -1 : d);
         while (exp_q.size() > 0) begin
            cyc_t it = exp_q.pop_front();
            MemReady = it.mr; fpu_done = it.fd;
            @(negedge clk);
            checks++;
            if (strb !== it.strb || (sel & it.sel_m) !== it.sel ||
                (it.alu && ALUOp !== 1'b1)) begin
               errors++;
               $display("FAIL rand instr %0d op %b cyc %0d: got strb=%b sel=%b aluop=%b, expected strb=%b sel=%b",
                        k, Op, n, strb, sel & it.sel_m, ALUOp, it.strb, it.sel);
            end
            n++;
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ldr();
      test_addi();
      test_branch_store();
      test_fpu("fpu_done5", 4);
      test_fpu("fpu_timeout", -1);
      test_fpu("fpu_coincident", TO - 1);
      test_reset_mid_fpu();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
